// File: rtl/timer_irq_ctrl_if.sv
// rtl/timer_irq_ctrl_if.sv - data-memory bus port of the compare/interrupt controller
interface timer_irq_ctrl_if;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, output addr, output wdata, input rdata);
  modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_irq_ctrl.sv
// rtl/timer_irq_ctrl.sv - compare channels against the ms timer, pending flags, level IRQ
// Periodic reload (PERIOD_i, CFG.PER) only when TIMER_IRQ_CTRL_PERIODIC_EN is defined.
module timer_irq_ctrl #(
  parameter int NCH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           time_i,
  timer_irq_ctrl_if.slave       bus,
  output logic                  irq_o
);

  logic [31:0]    time_q;
  logic           gen_q;
  logic [NCH-1:0] pending_q;
  logic [NCH-1:0] ie_q;
  logic [NCH-1:0] en_q;
  logic [31:0]    cmp_q [NCH];
  logic [NCH-1:0] per_q;
  logic [31:0]    period_q [NCH];

`ifndef TIMER_IRQ_CTRL_PERIODIC_EN
  assign per_q    = '0;
  assign period_q = '{default: '0};
`endif

  logic           tick;
  logic [NCH-1:0] fire;
  logic [NCH-1:0] w1c;
  int             addr_idx;

  assign tick     = (time_i != time_q);
  assign addr_idx = 32'(bus.addr);
  assign w1c      = (bus.we && addr_idx == 1) ? bus.wdata[NCH-1:0] : '0;
  assign irq_o    = |(pending_q & ie_q);

  always_comb begin
    fire = '0;
    for (int i = 0; i < NCH; i++) begin
      fire[i] = tick && gen_q && en_q[i] && (time_i == cmp_q[i]);
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (addr_idx)
      0:       bus.rdata = {31'd0, gen_q};
      1:       bus.rdata = 32'(pending_q);
      2:       bus.rdata = time_i;
      3:       bus.rdata = 32'(ie_q);
      default: bus.rdata = '0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      if (addr_idx == 4 + 3 * i) bus.rdata = cmp_q[i];
      if (addr_idx == 5 + 3 * i) bus.rdata = period_q[i];
      if (addr_idx == 6 + 3 * i) bus.rdata = {30'd0, per_q[i], en_q[i]};
    end
  end

  // Software writes sit after the hardware updates so they win on collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      time_q    <= '0;
      gen_q     <= 1'b0;
      pending_q <= '0;
      ie_q      <= '0;
      en_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        cmp_q[i] <= '0;
`ifdef TIMER_IRQ_CTRL_PERIODIC_EN
        period_q[i] <= '0;
`endif
      end
`ifdef TIMER_IRQ_CTRL_PERIODIC_EN
      per_q <= '0;
`endif
    end else begin
      time_q    <= time_i;
      pending_q <= (pending_q & ~w1c) | fire;
      if (bus.we && addr_idx == 0) gen_q <= bus.wdata[0];
      if (bus.we && addr_idx == 3) ie_q  <= bus.wdata[NCH-1:0];
      for (int i = 0; i < NCH; i++) begin
        if (fire[i]) begin
          if (per_q[i] && period_q[i] != '0) begin
            cmp_q[i] <= cmp_q[i] + period_q[i];
          end else begin
            en_q[i] <= 1'b0;
          end
        end
        if (bus.we && addr_idx == 4 + 3 * i) cmp_q[i] <= bus.wdata;
`ifdef TIMER_IRQ_CTRL_PERIODIC_EN
        if (bus.we && addr_idx == 5 + 3 * i) period_q[i] <= bus.wdata;
        if (bus.we && addr_idx == 6 + 3 * i) per_q[i] <= bus.wdata[1];
`endif
        if (bus.we && addr_idx == 6 + 3 * i) en_q[i] <= bus.wdata[0];
      end
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb/tb_timer_irq_ctrl.sv - scoreboard bench for timer_irq_ctrl against a register-level model
module tb_timer_irq_ctrl;

`ifdef TIMER_IRQ_CTRL_PERIODIC_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] time_in = '0;
  logic        irq;

  timer_irq_ctrl_if bus_if ();

  timer_irq_ctrl #(.NCH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .time_i (time_in),
    .bus    (bus_if.slave),
    .irq_o  (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t  exp_q [$];
  string tag_q [$];
  bit    sample_en = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;
  logic [31:0] cur_t = '0;

  bit          m_gen;
  bit [3:0]    m_pend;
  bit [3:0]    m_ie;
  bit          m_en [4];
  bit          m_per [4];
  logic [31:0] m_cmp [4];
  logic [31:0] m_period [4];
  logic [31:0] m_time;

  function automatic void m_reset();
    m_gen = 0; m_pend = '0; m_ie = '0; m_time = '0;
    for (int i = 0; i < 4; i++) begin
      m_en[i] = 0; m_per[i] = 0; m_cmp[i] = '0; m_period[i] = '0;
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a, input logic [31:0] t);
    int ch, k;
    case (a)
      4'd0: return {31'd0, m_gen};
      4'd1: return {28'd0, m_pend};
      4'd2: return t;
      4'd3: return {28'd0, m_ie};
      default: begin
        ch = (int'(a) - 4) / 3;
        k  = (int'(a) - 4) % 3;
        if (k == 0) return m_cmp[ch];
        if (k == 1) return m_period[ch];
        return {30'd0, m_per[ch], m_en[ch]};
      end
    endcase
  endfunction

  function automatic logic m_irq();
    return |(m_pend & m_ie);
  endfunction

  function automatic void m_apply(input logic [31:0] t, input logic we,
                                  input logic [3:0] a, input logic [31:0] d);
    bit [3:0] hit = '0;
    int ch, k;
    if (m_gen && t != m_time)
      for (int i = 0; i < 4; i++) if (m_en[i] && m_cmp[i] == t) hit[i] = 1;
    if (we && a == 4'd1) m_pend = m_pend & ~d[3:0];
    m_pend = m_pend | hit;
    for (int i = 0; i < 4; i++) begin
      if (hit[i]) begin
        if (m_per[i] && m_period[i] != 0) m_cmp[i] = m_cmp[i] + m_period[i];
        else m_en[i] = 0;
      end
    end
    if (we) begin
      if (a == 4'd0) m_gen = d[0];
      else if (a == 4'd3) m_ie = d[3:0];
      else if (a >= 4'd4) begin
        ch = (int'(a) - 4) / 3;
        k  = (int'(a) - 4) % 3;
        if (k == 0) m_cmp[ch] = d;
        else if (k == 1) begin
          if (PERIODIC) m_period[ch] = d;
        end else begin
          m_en[ch] = d[0];
          if (PERIODIC) m_per[ch] = d[1];
        end
      end
    end
    m_time = t;
  endfunction

  task automatic step(input logic [31:0] t, input logic we, input logic [3:0] a,
                      input logic [31:0] d, input string tag);
    exp_t e;
    time_in = t; bus_if.we = we; bus_if.addr = a; bus_if.wdata = d;
    e.rd = m_read(a, t);
    e.irq = m_irq();
    exp_q.push_back(e);
    tag_q.push_back(tag);
    sample_en = 1'b1;
    @(posedge clk);
    m_apply(t, we, a, d);
    #1;
    sample_en = 1'b0;
    cur_t = t;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(cur_t, 1'b1, a, d, "write_cycle");
  endtask

  task automatic rd(input logic [3:0] a, input string tag);
    step(cur_t, 1'b0, a, '0, tag);
  endtask

  task automatic tk(input logic [31:0] t, input string tag);
    step(t, 1'b0, 4'd1, '0, tag);
  endtask

  task automatic do_reset(input logic [31:0] t);
    rst_n = 1'b0; time_in = t; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur_t = t;
  endtask

  always @(negedge clk) begin
    if (sample_en) begin
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow: sample with no expected entry");
      end else begin
        exp_t e;
        string tg;
        e = exp_q.pop_front();
        tg = tag_q.pop_front();
        vectors++;
        if (bus_if.rdata !== e.rd || irq !== e.irq) begin
          miscompares++;
          $display("FAIL %s: addr=%0d rdata=%h irq=%b, expected rdata=%h irq=%b",
                   tg, bus_if.addr, bus_if.rdata, irq, e.rd, e.irq);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    m_reset();

    do_reset(32'd500);
    for (int a = 0; a < 16; a++) step(32'd500, 1'b0, 4'(a), '0, "reset_read");
    tk(32'd501, "reset_tick");
    tk(32'd502, "reset_tick");
    tk(32'd503, "reset_tick");

    wr(4'd0, 32'd1); wr(4'd3, 32'd1); wr(4'd4, 32'd10); wr(4'd6, 32'd1);
    tk(32'd9, "oneshot_pre");
    tk(32'd10, "oneshot_edge");
    tk(32'd10, "oneshot_pending");
    rd(4'd6, "oneshot_cfg_cleared");
    wr(4'd1, 32'd1);
    rd(4'd1, "oneshot_w1c");

    wr(4'd4, 32'd12);
    tk(32'd12, "enable_at_match");
    wr(4'd6, 32'd1);
    tk(32'd12, "enable_at_match_hold");
    tk(32'd12, "enable_at_match_hold");
    tk(32'd13, "enable_at_match_next");
    wr(4'd6, 32'd0);

    wr(4'd3, 32'd3); wr(4'd7, 32'd100); wr(4'd8, 32'd50); wr(4'd9, 32'd3);
    tk(32'd99, "per_pre");
    tk(32'd100, "per_edge");
    rd(4'd7, "per_cmp_reload");
    rd(4'd1, "per_pending");
    wr(4'd1, 32'd2);
    tk(32'd150, "per_second_edge");
    rd(4'd1, "per_second_pending");
    wr(4'd1, 32'd2);
    wr(4'd7, 32'hFFFF_FFF0); wr(4'd8, 32'h20);
    rd(4'd8, "per_period_rd");
    tk(32'hFFFF_FFF0, "per_wrap_edge");
    rd(4'd7, "per_wrap_cmp");
    wr(4'd9, 32'd0); wr(4'd1, 32'hF);

    wr(4'd4, 32'd200); wr(4'd5, 32'd5);
    rd(4'd5, "period0_rd");
    wr(4'd6, 32'd3);
    rd(4'd6, "cfg0_rd");
    tk(32'd200, "ch0_fire");
    rd(4'd1, "ch0_pending");
    wr(4'd1, 32'd1);
    tk(32'd205, "ch0_second");
    rd(4'd1, "ch0_second_pending");
    wr(4'd6, 32'd0); wr(4'd1, 32'hF);

    wr(4'd10, 32'd300); wr(4'd12, 32'd1);
    tk(32'd299, "race_pre");
    step(32'd300, 1'b1, 4'd1, 32'd4, "race_w1c");
    rd(4'd1, "race_pending_kept");
    wr(4'd1, 32'hF);

    wr(4'd0, 32'd0); wr(4'd4, 32'd60); wr(4'd6, 32'd1);
    tk(32'd59, "gen0_pre");
    tk(32'd60, "gen0_edge");
    tk(32'd61, "gen0_after");
    rd(4'd6, "gen0_en_kept");

    do_reset(cur_t);
    for (int a = 0; a < 16; a++) step(cur_t, 1'b0, 4'(a), '0, "midreset_read");

    wr(4'd0, 32'd1); wr(4'd3, 32'd1); wr(4'd4, 32'd40); wr(4'd7, 32'd40);
    wr(4'd6, 32'd1); wr(4'd9, 32'd1);
    tk(32'd39, "two_ch_pre");
    tk(32'd40, "two_ch_edge");
    rd(4'd1, "two_ch_status");
    wr(4'd1, 32'd1);
    rd(4'd1, "two_ch_clear");

    for (int n = 0; n < 600; n++) begin
      logic [31:0] t;
      logic [3:0]  a;
      logic [31:0] d;
      int r;
      r = int'($urandom_range(0, 99));
      t = cur_t;
      if (r < 60) t = cur_t + 1;
      else if (r < 62) t = $urandom;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) < 35) begin
        case (a)
          4'd0: d = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'd1;
          4'd1, 4'd3: d = $urandom;
          default: begin
            if ((int'(a) - 4) % 3 == 0) d = cur_t + $urandom_range(1, 8);
            else if ((int'(a) - 4) % 3 == 1) d = $urandom_range(0, 4);
            else d = $urandom_range(0, 3);
          end
        endcase
        step(t, 1'b1, a, d, "random_write");
      end else begin
        step(t, 1'b0, a, '0, "random_read");
      end
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
